// File: rtl/mcpu_core_icarb_pkg.sv
// mcpu_core_icarb_pkg: shared owner encoding, owner-queue entry type and starve counter width
package mcpu_core_icarb_pkg;
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_PF = 1'b1;
  localparam int STARVE_W = 3;
  typedef struct packed {
    logic owner;
    logic killed;
  } owner_entry_t;
endpackage

// File: rtl/mcpu_core_icarb_tagq.sv
// mcpu_core_icarb_tagq: in-order owner FIFO of outstanding I$ lookups with broadcast fetch kill
module mcpu_core_icarb_tagq
  import mcpu_core_icarb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clkrst_core_clk,
  input  logic         clkrst_core_rst,
  input  logic         push,
  input  owner_entry_t push_entry,
  input  logic         pop,
  input  logic         kill_fetch,
  output owner_entry_t head,
  output logic [CW-1:0] count
);
  owner_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = mem[rd_ptr];
  // Kill broadcast is applied before the push so a same-cycle push keeps its own killed bit
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_fetch && mem[i].owner == OWNER_FETCH) mem[i].killed <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/mcpu_core_icache_arb.sv
// mcpu_core_icache_arb: shares the I$ lookup port between fetch and prefetch, routes in-order responses
// Optional starvation override for prefetch enabled by MCPU_ICARB_STARVE_EN.
module mcpu_core_icache_arb
  import mcpu_core_icarb_pkg::*;
#(
  parameter int VADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst,
  input  logic               pipe_flush,
  input  logic               f_req_valid,
  input  logic [VADDR_W-1:0] f_req_vaddr,
  output logic               f_req_ready,
  output logic               f_rsp_valid,
  output logic [DATA_W-1:0]  f_rsp_data,
  input  logic               p_req_valid,
  input  logic [VADDR_W-1:0] p_req_vaddr,
  output logic               p_req_ready,
  output logic               p_rsp_valid,
  output logic [DATA_W-1:0]  p_rsp_data,
  output logic               ic_req_valid,
  output logic [VADDR_W-1:0] ic_req_vaddr,
  input  logic               ic_req_ready,
  input  logic               ic_rsp_valid,
  input  logic [DATA_W-1:0]  ic_rsp_data,
  output logic               arb_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  owner_entry_t head, push_entry;
  logic [CW-1:0] count;
  logic live, pf_force, grant_f, grant_p, can_issue, push, pop, empty;
`ifdef MCPU_ICARB_STARVE_EN
  logic [STARVE_W-1:0] starve_cnt;
  assign pf_force = starve_cnt >= STARVE_W'(STARVE_LIMIT);
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) starve_cnt <= '0;
    else if (!p_req_valid || p_req_ready) starve_cnt <= '0;
    else starve_cnt <= starve_cnt + STARVE_W'(starve_cnt != '1);
  end
`else
  assign pf_force = 1'b0;
`endif
  assign live = !clkrst_core_rst;
  assign empty = count == '0;
  assign grant_p = p_req_valid & (!f_req_valid | pf_force);
  assign grant_f = f_req_valid & !grant_p;
  // A response popping this cycle frees a slot even when the queue is full
  assign can_issue = (count < CW'(DEPTH)) | ic_rsp_valid;
  assign ic_req_valid = live & can_issue & (f_req_valid | p_req_valid);
  assign ic_req_vaddr = grant_p ? p_req_vaddr : f_req_vaddr;
  assign f_req_ready = live & grant_f & can_issue & ic_req_ready;
  assign p_req_ready = live & grant_p & can_issue & ic_req_ready;
  assign push = f_req_ready | p_req_ready;
  assign push_entry = '{owner: p_req_ready ? OWNER_PF : OWNER_FETCH, killed: f_req_ready & pipe_flush};
  assign pop = live & ic_rsp_valid & !empty;
  assign f_rsp_valid = pop & head.owner == OWNER_FETCH & !head.killed & !pipe_flush;
  assign p_rsp_valid = pop & head.owner == OWNER_PF;
  assign f_rsp_data = ic_rsp_data;
  assign p_rsp_data = ic_rsp_data;
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) arb_err <= 1'b0;
    else if (ic_rsp_valid && empty) arb_err <= 1'b1;
  end
  mcpu_core_icarb_tagq #(.DEPTH(DEPTH)) u_tagq (
    .clkrst_core_clk(clkrst_core_clk),
    .clkrst_core_rst(clkrst_core_rst),
    .push(push),
    .push_entry(push_entry),
    .pop(pop),
    .kill_fetch(pipe_flush),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_mcpu_core_icache_arb.sv
// tb_mcpu_core_icache_arb: directed and random checks against a queue-based reference model
module tb_mcpu_core_icache_arb;
  localparam int VW = 28;
  localparam int DW = 128;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef MCPU_ICARB_STARVE_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, fv = 1'b0, pv = 1'b0, rdy = 1'b0, rspv = 1'b0;
  logic [VW-1:0] fa = '0, pa = '0, icva;
  logic [DW-1:0] rd = '0, fd, pd;
  logic frdy, prdy, frsp, prsp, icv, err;
  typedef struct {bit pf; bit killed;} ent_t;
  ent_t q[$];
  int starve = 0, n_assert = 0, n_fail = 0;
  bit merr = 1'b0;
  logic o_icv, o_fr, o_pr, o_frsp, o_prsp, o_err;
  logic [VW-1:0] o_va;
  logic [DW-1:0] o_fd, o_pd;

  always #5 clk = ~clk;

  mcpu_core_icache_arb #(.VADDR_W(VW), .DATA_W(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clkrst_core_clk(clk), .clkrst_core_rst(rst), .pipe_flush(flush),
    .f_req_valid(fv), .f_req_vaddr(fa), .f_req_ready(frdy), .f_rsp_valid(frsp), .f_rsp_data(fd),
    .p_req_valid(pv), .p_req_vaddr(pa), .p_req_ready(prdy), .p_rsp_valid(prsp), .p_rsp_data(pd),
    .ic_req_valid(icv), .ic_req_vaddr(icva), .ic_req_ready(rdy),
    .ic_rsp_valid(rspv), .ic_rsp_data(rd), .arb_err(err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit f_v, input logic [VW-1:0] f_a, input bit p_v,
                     input logic [VW-1:0] p_a, input bit ic_r, input bit r_v,
                     input logic [DW-1:0] r_d, input bit fl);
    bit gp, gf, can, e_icv, e_fr, e_pr, has, e_frsp, e_prsp, stray;
    @(negedge clk);
    rst = r; fv = f_v; fa = f_a; pv = p_v; pa = p_a; rdy = ic_r; rspv = r_v; rd = r_d; flush = fl;
    #1;
    if (r) begin q.delete(); starve = 0; merr = 1'b0; end
    gp = p_v && (!f_v || (SE && starve >= LIMIT));
    gf = f_v && !gp;
    can = q.size() < DEPTH || r_v;
    e_icv = !r && can && (f_v || p_v);
    e_fr = !r && gf && can && ic_r;
    e_pr = !r && gp && can && ic_r;
    has = !r && r_v && q.size() > 0;
    stray = !r && r_v && q.size() == 0;
    e_frsp = has && !q[0].pf && !q[0].killed && !fl;
    e_prsp = has && q[0].pf;
    o_icv = icv; o_fr = frdy; o_pr = prdy; o_frsp = frsp; o_prsp = prsp; o_err = err;
    o_va = icva; o_fd = fd; o_pd = pd;
    chk("ic_req_valid", icv, e_icv);
    chk("f_req_ready", frdy, e_fr);
    chk("p_req_ready", prdy, e_pr);
    chk("f_rsp_valid", frsp, e_frsp);
    chk("p_rsp_valid", prsp, e_prsp);
    chk("arb_err", err, merr);
    if (e_icv) chk("ic_req_vaddr", icva, gp ? p_a : f_a);
    if (e_frsp) chk("f_rsp_data", fd, r_d);
    if (e_prsp) chk("p_rsp_data", pd, r_d);
    if (!r) begin
      if (has) void'(q.pop_front());
      if (fl) foreach (q[i]) if (!q[i].pf) q[i].killed = 1'b1;
      if (e_fr || e_pr) q.push_back('{pf: e_pr, killed: e_fr && fl});
      starve = (e_pr || !p_v) ? 0 : (starve < 7 ? starve + 1 : 7);
      if (stray) merr = 1'b1;
    end
  endtask

  initial begin
    cyc(1, 1, 'h1, 1, 'h2, 1, 1, 'h3, 0);
    chk("reset_icv", o_icv, 0);
    chk("reset_err", o_err, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // 1: simultaneous requests, fetch wins
    cyc(0, 1, 'h10, 1, 'h20, 1, 0, 0, 0);
    chk("t1_vaddr", o_va, 'h10);
    chk("t1_f_ready", o_fr, 1);
    chk("t1_p_ready", o_pr, 0);
    // 2 and 4: fill queue, blocked when full, unblocked by same-cycle response
    cyc(0, 0, 0, 1, 'h20, 1, 0, 0, 0);
    cyc(0, 1, 'h30, 0, 0, 1, 0, 0, 0);
    chk("t4_full_icv", o_icv, 0);
    cyc(0, 1, 'h30, 0, 0, 1, 1, 128'hD0, 0);
    chk("t2_f_rsp", o_frsp, 1);
    chk("t2_f_data", o_fd, 128'hD0);
    chk("t4_full_rsp_ready", o_fr, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 128'hD1, 0);
    chk("t2_p_rsp", o_prsp, 1);
    chk("t2_p_data", o_pd, 128'hD1);
    cyc(0, 0, 0, 0, 0, 1, 1, 128'hD2, 0);
    // 3: flush kills both outstanding fetches
    cyc(0, 1, 'h40, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 'h50, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 128'hE0, 0);
    chk("t3_drop0", o_frsp, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 128'hE1, 0);
    chk("t3_drop1", o_frsp, 0);
    // 6: stray response
    cyc(0, 0, 0, 0, 0, 1, 1, 128'hE2, 0);
    chk("t6_stray_rsp", o_frsp | o_prsp, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("t6_err", o_err, 1);
    // 5: starvation override
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, VW'(i), 1, 'h100, 1, i > 1, DW'(i), 0);
      if (i < 5) chk("t5_no_pf_early", o_pr, 0);
      if (i == 5) chk("t5_pf_grant", o_pr, SE);
    end
    cyc(0, 0, 0, 0, 0, 1, 1, 'h7, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 'h8, 0);
    // reset mid-flight empties the queue
    cyc(0, 1, 'h60, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 'h70, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 'h80, 1, 'h90, 1, 1, 'h9, 0);
    chk("rst_mid_icv", o_icv, 0);
    chk("rst_mid_frsp", o_frsp, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 'hA, 0);
    chk("rst_mid_empty", o_frsp | o_prsp, 0);
    chk("rst_mid_err", o_err, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r_v;
      r_v = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, VW'($urandom), $urandom_range(0, 1) == 1,
          VW'($urandom), $urandom_range(0, 3) != 0, r_v, {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
